// File: rtl/bilstm_fifo_wr_arbiter.sv
// Write-side arbiter sharing one FIFO between the forward and backward BiLSTM cells; whole-vector
// grants, round-robin on ties. Optional sticky error checker under BILSTM_ARB_ERR_CHECK_EN.
module bilstm_fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 8,
  localparam int unsigned CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fwd_valid,
  input  logic signed [DATA_WIDTH-1:0] fwd_data,
  output logic                         fwd_ready,
  input  logic                         bwd_valid,
  input  logic signed [DATA_WIDTH-1:0] bwd_data,
  output logic                         bwd_ready,
  input  logic                         fifo_full,
  input  logic                         fifo_wr_ack,
  input  logic                         fifo_overflow,
  output logic                         fifo_wr_en,
  output logic signed [DATA_WIDTH-1:0] fifo_data_in,
  output logic                         active_dir,
  output logic                         busy,
  output logic [CNT_W-1:0]             burst_cnt,
  output logic                         burst_done,
  output logic                         burst_dir,
  output logic                         err
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StGrantFwd, StGrantBwd} state_e;

  state_e           state_q, state_d;
  logic             last_dir_q, last_dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             bdir_q, bdir_d;

  logic cur_dir, grant_valid, other_valid, win_dir;

  assign cur_dir     = (state_q == StGrantBwd);
  assign grant_valid = cur_dir ? bwd_valid : fwd_valid;
  assign other_valid = cur_dir ? fwd_valid : bwd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_dir_q <= 1'b1;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      bdir_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      bdir_q     <= bdir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    bdir_d     = bdir_q;
    win_dir    = (fwd_valid && bwd_valid) ? !last_dir_q : bwd_valid;
    unique case (state_q)
      StIdle: begin
        if (fwd_valid || bwd_valid) begin
          state_d    = win_dir ? StGrantBwd : StGrantFwd;
          last_dir_d = win_dir;
          cnt_d      = '0;
        end
      end
      StGrantFwd, StGrantBwd: begin
        if (fifo_wr_en) begin
          if (cnt_q == LastCnt) begin
            done_d = 1'b1;
            bdir_d = cur_dir;
            cnt_d  = '0;
            // Hand over to the other side first so a waiting direction is never starved.
            if (other_valid) begin
              state_d    = cur_dir ? StGrantFwd : StGrantBwd;
              last_dir_d = !cur_dir;
            end else if (grant_valid) begin
              last_dir_d = cur_dir;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fwd_ready    = !rst && (state_q == StGrantFwd) && !fifo_full;
    bwd_ready    = !rst && (state_q == StGrantBwd) && !fifo_full;
    fifo_wr_en   = !rst && (state_q != StIdle) && grant_valid && !fifo_full;
    fifo_data_in = '0;
    if (!rst && state_q != StIdle) begin
      fifo_data_in = cur_dir ? bwd_data : fwd_data;
    end
  end

  assign busy       = (state_q != StIdle);
  assign active_dir = cur_dir;
  assign burst_cnt  = cnt_q;
  assign burst_done = done_q;
  assign burst_dir  = bdir_q;

`ifdef BILSTM_ARB_ERR_CHECK_EN
  logic wr_en_q, err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wr_en_q <= fifo_wr_en;
      err_q   <= err_q || fifo_overflow || (wr_en_q && !fifo_wr_ack);
    end
  end

  assign err = err_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = fifo_wr_ack ^ fifo_overflow;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bilstm_fifo_wr_arbiter.sv
// Randomized bench for bilstm_fifo_wr_arbiter against a per-cycle behavioural model of the
// grant/burst rules; err expectation follows BILSTM_ARB_ERR_CHECK_EN.
module tb_bilstm_fifo_wr_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 8;
  localparam int unsigned CW = $clog2(BL + 1);
`ifdef BILSTM_ARB_ERR_CHECK_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 fwd_valid, bwd_valid, fwd_ready, bwd_ready;
  logic signed [DW-1:0] fwd_data, bwd_data, fifo_data_in;
  logic                 fifo_full, fifo_wr_ack, fifo_overflow, fifo_wr_en;
  logic                 active_dir, busy, burst_done, burst_dir, err;
  logic [CW-1:0]        burst_cnt;

  bilstm_fifo_wr_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
    .bwd_valid(bwd_valid), .bwd_data(bwd_data), .bwd_ready(bwd_ready),
    .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
    .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .active_dir(active_dir), .busy(busy), .burst_cnt(burst_cnt),
    .burst_done(burst_done), .burst_dir(burst_dir), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: grant held, granted direction, tie memory, words written, completion pulse.
  bit          m_busy, m_dir, m_last, m_done, m_bdir, m_err, m_prev_wr;
  int          m_cnt;
  logic [31:0] fd, bd;

  task automatic model_reset();
    m_busy = 0; m_dir = 0; m_last = 1; m_cnt = 0;
    m_done = 0; m_bdir = 0; m_err = 0; m_prev_wr = 0;
  endtask

  task automatic step(input bit r, input bit fv, input bit bv, input bit full, input bit ovf);
    bit exp_wr, gv, ov;
    logic [31:0] exp_data;
    @(negedge clk);
    rst = r; fwd_valid = fv; bwd_valid = bv; fifo_full = full; fifo_overflow = ovf;
    fifo_wr_ack = m_prev_wr; fwd_data = fd; bwd_data = bd;
    #1;
    gv       = m_dir ? bv : fv;
    ov       = m_dir ? fv : bv;
    exp_wr   = !r && m_busy && gv && !full;
    exp_data = (r || !m_busy) ? 32'd0 : (m_dir ? bd : fd);
    check_eq("fifo_wr_en", fifo_wr_en, exp_wr);
    check_eq("fwd_ready", fwd_ready, !r && m_busy && !m_dir && !full);
    check_eq("bwd_ready", bwd_ready, !r && m_busy && m_dir && !full);
    check_eq("fifo_data_in", fifo_data_in, {{32{exp_data[31]}}, exp_data});
    check_eq("busy", busy, m_busy);
    if (m_busy) check_eq("active_dir", active_dir, m_dir);
    check_eq("burst_cnt", burst_cnt, m_cnt);
    check_eq("burst_done", burst_done, m_done);
    if (m_done) check_eq("burst_dir", burst_dir, m_bdir);
    check_eq("err", err, m_err);
    if (r) begin
      model_reset();
    end else begin
      m_err     = m_err || (ErrEn && (ovf || (m_prev_wr && !fifo_wr_ack)));
      m_prev_wr = exp_wr;
      m_done    = 0;
      if (exp_wr) begin
        if (m_dir) bd = $urandom; else fd = $urandom;
      end
      if (!m_busy) begin
        if (fv || bv) begin
          m_dir  = (fv && bv) ? !m_last : bv;
          m_last = m_dir;
          m_busy = 1;
          m_cnt  = 0;
        end
      end else if (exp_wr) begin
        m_cnt++;
        if (m_cnt == BL) begin
          m_done = 1;
          m_bdir = m_dir;
          m_cnt  = 0;
          if (ov) begin
            m_dir  = !m_dir;
            m_last = m_dir;
          end else if (gv) begin
            m_last = m_dir;
          end else begin
            m_busy = 0;
          end
        end
      end
    end
  endtask

  initial begin
    fd = $urandom; bd = $urandom;
    rst = 1; fwd_valid = 0; bwd_valid = 0; fwd_data = '0; bwd_data = '0;
    fifo_full = 0; fifo_wr_ack = 0; fifo_overflow = 0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1, 0, 0, 0, 0);
    // Single-direction burst.
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Tie and round-robin, back-to-back bursts.
    for (int i = 0; i < 30; i++) step(0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    // Full stall: fwd fills, then bwd waits behind a full FIFO.
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0);
    // Mid-burst valid drop while the other side waits.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0);
    // Reset mid-burst.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           $urandom_range(0, 3) == 0, 1'b0);
    // Overflow pulse, sticky until reset.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
